// File: rtl/spi_reg_readback.sv
// spi_reg_readback: SPI mode-0 read path for the PWM register bank.
// Decodes 16-bit host frames {rw, addr[6:0], data[7:0]} and, on reads
// (rw=0), shifts the addressed register back on cipo during the data byte.
// Optional: define SPI_RB_BURST_EN to auto-increment the address and keep
// streaming bytes while ncs stays low after the 16th sclk rise.
module spi_reg_readback #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic       cipo,
  output logic       cipo_oe,
  output logic       rd_done,
  output logic [6:0] rd_addr,
  output logic       frame_err
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, SKIP, WAIT} state_t;

  logic [SYNC_STAGES-1:0] sclk_s, copi_s, ncs_s;
  logic sclk_d, ncs_d;
  logic sclk_now, copi_now, ncs_now;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  state_t     state;
  logic [3:0] cnt;
  logic [6:0] cmd_sr;
  logic [7:0] shift_sr;
  logic       first;
  logic       is_read;
  logic [6:0] cur_addr;
  logic [6:0] snap_addr;
  logic [7:0] snap_val;
`ifdef SPI_RB_BURST_EN
  logic       byte_ok;
  logic [6:0] last_addr;
`endif

  // Pin synchronizers plus one history flop each for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s <= '0;
      copi_s <= '0;
      ncs_s  <= '1;
      sclk_d <= 1'b0;
      ncs_d  <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
      copi_s <= {copi_s[SYNC_STAGES-2:0], copi};
      ncs_s  <= {ncs_s[SYNC_STAGES-2:0], ncs};
      sclk_d <= sclk_s[SYNC_STAGES-1];
      ncs_d  <= ncs_s[SYNC_STAGES-1];
    end
  end

  assign sclk_now  = sclk_s[SYNC_STAGES-1];
  assign copi_now  = copi_s[SYNC_STAGES-1];
  assign ncs_now   = ncs_s[SYNC_STAGES-1];
  assign sclk_rise = sclk_now & ~sclk_d;
  assign sclk_fall = ~sclk_now & sclk_d;
  assign ncs_rise  = ncs_now & ~ncs_d;
  assign ncs_fall  = ~ncs_now & ncs_d;

  // Address for the next snapshot: the decoded address at the end of the
  // command byte, otherwise the successor of the current address (burst).
  always_comb begin
    snap_addr = (state == CMD) ? {cmd_sr[5:0], copi_now} : cur_addr + 7'd1;
    case (snap_addr)
      7'd0:    snap_val = en_reg_out_7_0;
      7'd1:    snap_val = en_reg_out_15_8;
      7'd2:    snap_val = en_reg_pwm_7_0;
      7'd3:    snap_val = en_reg_pwm_15_8;
      7'd4:    snap_val = pwm_duty_cycle;
      default: snap_val = 8'h00;
    endcase
    if (int'(snap_addr) >= NUM_REGS) snap_val = 8'h00;
  end

  assign cipo = shift_sr[7];

  // Frame FSM; ncs rise has priority over a coincident sclk edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_sr    <= '0;
      shift_sr  <= '0;
      first     <= 1'b0;
      is_read   <= 1'b0;
      cur_addr  <= '0;
      cipo_oe   <= 1'b0;
      rd_done   <= 1'b0;
      rd_addr   <= '0;
      frame_err <= 1'b0;
`ifdef SPI_RB_BURST_EN
      byte_ok   <= 1'b0;
      last_addr <= '0;
`endif
    end else begin
      rd_done   <= 1'b0;
      frame_err <= 1'b0;
      if (ncs_rise) begin
        case (state)
          WAIT: if (is_read) begin
            rd_done <= 1'b1;
            rd_addr <= cur_addr;
          end
          CMD, SKIP: frame_err <= 1'b1;
          DATA: begin
`ifdef SPI_RB_BURST_EN
            if (byte_ok) begin
              rd_done <= 1'b1;
              rd_addr <= last_addr;
            end else frame_err <= 1'b1;
`else
            frame_err <= 1'b1;
`endif
          end
          default: ;
        endcase
        state    <= IDLE;
        cipo_oe  <= 1'b0;
        shift_sr <= '0;
      end else if (ncs_fall) begin
        // Also restarts a frame if ncs glitched high-low without a clean end.
        state    <= CMD;
        cnt      <= '0;
        cipo_oe  <= 1'b0;
        shift_sr <= '0;
`ifdef SPI_RB_BURST_EN
        byte_ok  <= 1'b0;
`endif
      end else if (sclk_rise) begin
        case (state)
          CMD: begin
            cmd_sr <= {cmd_sr[5:0], copi_now};
            cnt    <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              // cmd_sr[6] holds bit15 (R/W) after seven shifts.
              if (!cmd_sr[6]) begin
                is_read  <= 1'b1;
                cur_addr <= snap_addr;
                shift_sr <= snap_val;
                first    <= 1'b1;
                cipo_oe  <= 1'b1;
                state    <= DATA;
              end else begin
                is_read <= 1'b0;
                state   <= SKIP;
              end
            end
          end
          DATA: begin
            cnt <= cnt + 4'd1;
            if (cnt[2:0] == 3'd7) begin
`ifdef SPI_RB_BURST_EN
              byte_ok   <= 1'b1;
              last_addr <= cur_addr;
              cur_addr  <= snap_addr;
              shift_sr  <= snap_val;
              first     <= 1'b1;
`else
              state    <= WAIT;
              cipo_oe  <= 1'b0;
              shift_sr <= '0;
`endif
            end
          end
          SKIP: begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) state <= WAIT;
          end
          default: ;
        endcase
      end else if (sclk_fall && state == DATA) begin
        // The MSB is already on cipo after a load; the first fall keeps it.
        if (first) first <= 1'b0;
        else       shift_sr <= {shift_sr[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_readback.sv
// Directed bench for spi_reg_readback: table of single frames plus
// hand-written sequences for mid-frame register change, abort, reset and burst.
module tb_spi_reg_readback;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, copi, ncs;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       cipo, cipo_oe, rd_done, frame_err;
  logic [6:0] rd_addr;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int fe_cnt = 0;

  spi_reg_readback #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4),
    .cipo(cipo), .cipo_oe(cipo_oe), .rd_done(rd_done), .rd_addr(rd_addr),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Count cycles each pulse output is high; a clean pulse adds exactly 1.
  always @(negedge clk) begin
    if (rd_done)   rd_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Host frame: sclk half period is 8 clks; cipo/oe sampled just before
  // each rise. rx/oe are left-aligned (bit 31 = first bit). lat = clks from
  // ncs rise to the first rd_done seen (-1 if none within 20 clks).
  task automatic frame(input logic [31:0] tx, input int nbits, input int chg_bit,
                       input logic [7:0] chg_val, output logic [31:0] rx,
                       output logic [31:0] oe, output int lat);
    rx = '0; oe = '0; lat = -1;
    ncs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      copi = tx[31-i];
      repeat (8) @(negedge clk);
      rx[31-i] = cipo;
      oe[31-i] = cipo_oe;
      sclk = 1'b1;
      if (i == chg_bit) r2 = chg_val;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    ncs = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rd_done && lat < 0) lat = k;
    end
  endtask

  typedef struct {
    logic [31:0] tx;
    logic [7:0]  exp_byte;
    logic [7:0]  exp_oe;
    int          exp_rd;
    logic [6:0]  exp_addr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] rx, oe;
    int lat, rd0, fe0;

    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    r0 = 8'h5A; r1 = 8'h81; r2 = 8'h3C; r3 = 8'h12; r4 = 8'hA5;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cipo", {31'b0, cipo}, 32'd0);
    chk("reset_oe", {31'b0, cipo_oe}, 32'd0);
    chk("reset_rd_done", {31'b0, rd_done}, 32'd0);
    chk("reset_frame_err", {31'b0, frame_err}, 32'd0);
    chk("reset_rd_addr", {25'b0, rd_addr}, 32'd0);

    vecs[0] = '{{1'b0, 7'h04, 8'h00, 16'h0}, 8'hA5, 8'hFF, 1, 7'h04};
    vecs[1] = '{{1'b0, 7'h10, 8'h00, 16'h0}, 8'h00, 8'hFF, 1, 7'h10};
    vecs[2] = '{{1'b1, 7'h02, 8'h55, 16'h0}, 8'h00, 8'h00, 0, 7'h10};
    vecs[3] = '{{1'b0, 7'h00, 8'hFF, 16'h0}, 8'h5A, 8'hFF, 1, 7'h00};
    vecs[4] = '{{1'b0, 7'h7F, 8'h00, 16'h0}, 8'h00, 8'hFF, 1, 7'h7F};

    foreach (vecs[v]) begin
      rd0 = rd_cnt; fe0 = fe_cnt;
      frame(vecs[v].tx, 16, -1, 8'h00, rx, oe, lat);
      chk($sformatf("v%0d_rx", v), {24'b0, rx[23:16]}, {24'b0, vecs[v].exp_byte});
      chk($sformatf("v%0d_oe_cmd", v), {24'b0, oe[31:24]}, 32'd0);
      chk($sformatf("v%0d_oe_data", v), {24'b0, oe[23:16]}, {24'b0, vecs[v].exp_oe});
      chk($sformatf("v%0d_rd_done", v), rd_cnt - rd0, vecs[v].exp_rd);
      chk($sformatf("v%0d_frame_err", v), fe_cnt - fe0, 32'd0);
      chk($sformatf("v%0d_rd_addr", v), {25'b0, rd_addr}, {25'b0, vecs[v].exp_addr});
      chk($sformatf("v%0d_oe_idle", v), {31'b0, cipo_oe}, 32'd0);
      if (vecs[v].exp_rd != 0) chk($sformatf("v%0d_latency", v), lat, 32'd3);
    end

    // Register changes after the snapshot must not reach the host.
    rd0 = rd_cnt;
    frame({1'b0, 7'h02, 8'h00, 16'h0}, 16, 10, 8'hFF, rx, oe, lat);
    chk("snap_rx", {24'b0, rx[23:16]}, 32'h3C);
    chk("snap_rd_done", rd_cnt - rd0, 32'd1);
    chk("snap_rd_addr", {25'b0, rd_addr}, 32'h02);
    r2 = 8'h3C;

    // Abort after 11 sclk cycles, then a normal read of addr 1.
    rd0 = rd_cnt; fe0 = fe_cnt;
    frame({1'b0, 7'h02, 8'h00, 16'h0}, 11, -1, 8'h00, rx, oe, lat);
    chk("abort_frame_err", fe_cnt - fe0, 32'd1);
    chk("abort_rd_done", rd_cnt - rd0, 32'd0);
    chk("abort_oe", {31'b0, cipo_oe}, 32'd0);
    rd0 = rd_cnt; fe0 = fe_cnt;
    frame({1'b0, 7'h01, 8'h00, 16'h0}, 16, -1, 8'h00, rx, oe, lat);
    chk("after_abort_rx", {24'b0, rx[23:16]}, 32'h81);
    chk("after_abort_rd_done", rd_cnt - rd0, 32'd1);
    chk("after_abort_frame_err", fe_cnt - fe0, 32'd0);
    chk("after_abort_rd_addr", {25'b0, rd_addr}, 32'h01);

    // Reset mid-frame: no pulses, outputs cleared, rd_addr back to 0.
    rd0 = rd_cnt; fe0 = fe_cnt;
    ncs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      copi = 1'b0;
      repeat (8) @(negedge clk);
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    ncs = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid_rd_done", rd_cnt - rd0, 32'd0);
    chk("rst_mid_frame_err", fe_cnt - fe0, 32'd0);
    chk("rst_mid_oe", {31'b0, cipo_oe}, 32'd0);
    chk("rst_mid_cipo", {31'b0, cipo}, 32'd0);
    chk("rst_mid_rd_addr", {25'b0, rd_addr}, 32'd0);

    // 24 sclk cycles reading addr 3 (0x12) with addr 4 = 0x34.
    r4 = 8'h34;
    rd0 = rd_cnt; fe0 = fe_cnt;
    frame({1'b0, 7'h03, 8'h00, 16'h0}, 24, -1, 8'h00, rx, oe, lat);
    chk("burst_byte0", {24'b0, rx[23:16]}, 32'h12);
    chk("burst_rd_done", rd_cnt - rd0, 32'd1);
    chk("burst_frame_err", fe_cnt - fe0, 32'd0);
`ifdef SPI_RB_BURST_EN
    chk("burst_byte1", {24'b0, rx[15:8]}, 32'h34);
    chk("burst_oe1", {24'b0, oe[15:8]}, 32'hFF);
    chk("burst_rd_addr", {25'b0, rd_addr}, 32'h04);
`else
    chk("burst_byte1", {24'b0, rx[15:8]}, 32'h00);
    chk("burst_oe1", {24'b0, oe[15:8]}, 32'h00);
    chk("burst_rd_addr", {25'b0, rd_addr}, 32'h03);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
